sipo_deser: RTL
===============

Name: sipo_deser

Overview:
Serial-to-parallel deserializer that consumes the single-bit stream produced by the 4-bit PISO stage, MSB first. It reassembles WIDTH-bit words and presents them on a valid/ready parallel output. A one-deep holding register decouples the shift path from the consumer. A sticky overrun flag reports words lost to consumer back-pressure.

Parameters:
WIDTH, 4, word width in bits; must be >= 2
MSB_FIRST, 1, 1 = first received bit lands in dout[WIDTH-1] (matches the PISO shift order); 0 = first bit lands in dout[0]

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-low reset (asserted when 0); all state cleared immediately
sin  in  1  serial data bit
sin_valid  in  1  sin is sampled at this clk edge when 1
clr  in  1  synchronous abort of the partially received word; does not affect the holding register
dout  out  WIDTH  assembled word (holding register)
dout_valid  out  1  holding register contains an unconsumed word
dout_ready  in  1  consumer accepts dout when dout_valid && dout_ready at a clk edge
overrun  out  1  sticky; a completed word was dropped
overrun_clr  in  1  synchronous clear of overrun
bit_cnt  out  $clog2(WIDTH)  number of bits of the current partial word received (debug/status)

Behaviour:
- Reset (rst=0, async): shift register=0, bit_cnt=0, dout=0, dout_valid=0, overrun=0. Release is synchronous to clk by the upstream reset synchroniser.
- Shift path, when sin_valid=1 and clr=0:
  - MSB_FIRST=1: sreg <= {sreg[WIDTH-2:0], sin}.
  - MSB_FIRST=0: sreg <= {sin, sreg[WIDTH-1:1]}.
  - bit_cnt increments. sin_valid=0 holds sreg and bit_cnt.
- Counter states: COLLECT (bit_cnt 0..WIDTH-2) and LAST (bit_cnt = WIDTH-1).
  - Accepting a bit in LAST completes a word; bit_cnt wraps to 0.
  - The completed word is the shifted value including that last bit.
- Word completion, edge N:
  - If the holding register is free (dout_valid=0), or is being drained at the same edge (dout_valid && dout_ready): dout <= completed word, dout_valid=1 from after edge N. Latency is one clk from the last bit's sampling edge to dout_valid visible.
  - Otherwise the word is dropped: dout unchanged, overrun <= 1, bit_cnt still wraps to 0.
- Handshake:
  - dout_valid && dout_ready with no completion at that edge: dout_valid <= 0. dout keeps its last value; it is don't-care for the consumer.
  - dout and dout_valid are stable while dout_valid=1 and dout_ready=0.
- clr=1:
  - bit_cnt <= 0, sreg <= 0, and the sin bit at that edge is ignored, even if sin_valid=1.
  - The holding register and handshake are unaffected; a drain at the same edge still completes.
- overrun:
  - Set on a dropped word; cleared by overrun_clr.
  - If a drop and overrun_clr occur at the same edge, set wins (overrun=1).
- Async reset asserted mid-word or with dout_valid=1 discards everything. No partial word survives.
- bit_cnt output reflects the registered counter value.

Decomposition:
- Shared package sipo_pkg holds:
  - default WIDTH (4), shared with the PISO stage
  - MSB_FIRST encoding constants
  - function for the counter width ($clog2 wrapper guarding WIDTH=2)
- One sub-module: sipo_shift_core. It contains the shift register, bit counter and word-complete pulse.
- sipo_deser adds the holding register, the handshake and overrun.
- Expected RTL size: about 150-220 lines total.

Test Plan:
- Reset then stream 1,0,1,1 with sin_valid=1 and dout_ready=1 -> dout_valid=1 for exactly one cycle, one clk after the 4th bit, dout=4'b1011; bit_cnt sequence 0,1,2,3,0.
- MSB_FIRST=0 build, same stream 1,0,1,1 -> dout=4'b1101.
- dout_ready=0; send 4'hA then 4'h5 -> dout holds 4'hA with dout_valid=1, overrun=1 after the 8th bit; raise dout_ready -> 4'hA consumed, dout_valid=0; pulse overrun_clr -> overrun=0.
- dout_ready pulsed at the same edge the 2nd word 4'h3 completes (first word 4'hC pending) -> no overrun, dout changes 4'hC->4'h3, dout_valid stays 1.
- Send 2 bits, assert clr with sin_valid=1 and sin=1, then send 0,1,1,0 -> bit_cnt=0 after clr; the next word is 4'h6.
- Assert rst=0 asynchronously mid-word and while dout_valid=1 -> dout=0, dout_valid=0, overrun=0, bit_cnt=0 before the next clk edge; the following 4-bit word 4'h9 is received correctly.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared constants for the PISO/SIPO serial link: default word width,
// bit-order encodings and the bit-counter width helper.
package sipo_pkg;

    localparam int DEF_WIDTH = 4;

    localparam int LSB_ORDER = 0;
    localparam int MSB_ORDER = 1;

    // $clog2(2) is 1 but $clog2(1) is 0; keep the counter at least one bit wide.
    function automatic int cnt_w(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Shift register and bit counter for the deserializer; flags the edge at
// which a full word is assembled and presents that word combinationally.
module sipo_shift_core
    import sipo_pkg::*;
#(
    parameter  int WIDTH     = DEF_WIDTH,
    parameter  int MSB_FIRST = MSB_ORDER,
    localparam int CW        = cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             clr,
    output logic [WIDTH-1:0] word,
    output logic             word_done,
    output logic [CW-1:0]    bit_cnt
);

    // Only WIDTH-1 history bits are stored: the bit that would fall off the
    // far end is never part of a completed word.
    logic [WIDTH-2:0] hist;
    logic [WIDTH-2:0] hist_nxt;
    logic             shift_en;

    assign shift_en = sin_valid & ~clr;

    generate
        if (MSB_FIRST == MSB_ORDER) begin : g_msb
            assign word     = {hist, sin};
            assign hist_nxt = word[WIDTH-2:0];
        end else begin : g_lsb
            assign word     = {sin, hist};
            assign hist_nxt = word[WIDTH-1:1];
        end
    endgenerate

    assign word_done = shift_en && (bit_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist    <= '0;
            bit_cnt <= '0;
        end else if (clr) begin
            hist    <= '0;
            bit_cnt <= '0;
        end else if (sin_valid) begin
            hist    <= hist_nxt;
            bit_cnt <= word_done ? '0 : bit_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/sipo_deser.sv
// Serial-to-parallel deserializer: one-deep holding register with a
// valid/ready output and a sticky overrun flag for words lost to back-pressure.
module sipo_deser
    import sipo_pkg::*;
#(
    parameter  int WIDTH     = DEF_WIDTH,
    parameter  int MSB_FIRST = MSB_ORDER,
    localparam int CW        = cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             clr,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             overrun,
    input  logic             overrun_clr,
    output logic [CW-1:0]    bit_cnt
);

    logic [WIDTH-1:0] word;
    logic             word_done;
    logic             slot_free;

    sipo_shift_core #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .sin       (sin),
        .sin_valid (sin_valid),
        .clr       (clr),
        .word      (word),
        .word_done (word_done),
        .bit_cnt   (bit_cnt)
    );

    // A drain at the same edge frees the slot for the incoming word.
    assign slot_free = ~dout_valid | dout_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (word_done && slot_free) begin
                dout       <= word;
                dout_valid <= 1'b1;
            end else if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end

            if (word_done && !slot_free)
                overrun <= 1'b1;
            else if (overrun_clr)
                overrun <= 1'b0;
        end
    end

endmodule
